seq_divmod: RTL and testbench

- Multi-cycle iterative divider/modulo unit with a start/done handshake.
- Datapath generator instantiates it when a DIV or MOD operation is scheduled across several states.
- Its quot/rem outputs feed REG stages directly; Done is the load enable for the controller.
- Restoring division, one quotient bit per clock. Trades area against the single-cycle combinational DIV/MOD components.

---
 rtl/seq_divmod.sv | 122 ++++++++++++
 tb/tb_seq_divmod.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_divmod.sv
// Iterative restoring divider/modulo: one quotient bit per clock, start/done handshake.
// Signed mode divides magnitudes and corrects signs when the result is written.
module seq_divmod #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 Done,
  output logic                 Busy,
  output logic                 DivByZero
);

  localparam int unsigned W  = DATAWIDTH;
  localparam int unsigned CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StZero, StFin} state_e;

  state_e         r_state;
  logic [W:0]     r_p;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_bmag;
  logic [W-1:0]   r_a;
  logic [CW-1:0]  r_cnt;
  logic           r_neg_q;
  logic           r_neg_r;

  logic           w_accept;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [W+1:0]   w_p_sh;
  logic [W+1:0]   w_sub;
  logic           w_fit;
  logic [W-1:0]   w_q_fin;
  logic [W-1:0]   w_r_fin;

  assign w_accept = Start && ((r_state == StIdle) || (r_state == StFin));
  assign w_a_neg  = (SIGNED != 0) && a[W-1];
  assign w_b_neg  = (SIGNED != 0) && b[W-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // One extra guard bit keeps the borrow of the trial subtraction exact.
  assign w_p_sh   = {r_p, r_q[W-1]};
  assign w_sub    = w_p_sh - {2'b00, r_bmag};
  assign w_fit    = ~w_sub[W+1];

  assign w_q_fin  = r_neg_q ? -r_q : r_q;
  assign w_r_fin  = r_neg_r ? -r_p[W-1:0] : r_p[W-1:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= StIdle;
      r_p       <= '0;
      r_q       <= '0;
      r_bmag    <= '0;
      r_a       <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StFin: begin
          Done <= 1'b0;
          if (w_accept) begin
            r_state <= (b == '0) ? StZero : StRun;
            r_q     <= w_a_mag;
            r_bmag  <= w_b_mag;
            r_a     <= a;
            r_p     <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            Busy    <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          if (r_cnt == CW'(W)) begin
            r_state   <= StFin;
            quot      <= w_q_fin;
            rem       <= w_r_fin;
            DivByZero <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
          end else begin
            r_p   <= w_fit ? w_sub[W:0] : w_p_sh[W:0];
            r_q   <= {r_q[W-2:0], w_fit};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StZero: begin
          if (r_cnt == CW'(1)) begin
            r_state   <= StFin;
            quot      <= '1;
            rem       <= r_a;
            DivByZero <= 1'b1;
            Done      <= 1'b1;
            Busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod: one unsigned and one signed 8-bit instance, directed plus random
// operations checked against plain integer division.
module tb_seq_divmod;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start [2];
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] quot [2];
  logic [7:0] rem  [2];
  logic       done [2];
  logic       busy [2];
  logic       dbz  [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q, exp_r;
  logic       exp_z;
  int         exp_lat;

  always #5 Clk = ~Clk;

  seq_divmod #(.DATAWIDTH(8), .SIGNED(0)) u_uns (
    .Clk(Clk), .Rst(Rst), .Start(start[0]), .a(a), .b(b), .quot(quot[0]), .rem(rem[0]),
    .Done(done[0]), .Busy(busy[0]), .DivByZero(dbz[0])
  );

  seq_divmod #(.DATAWIDTH(8), .SIGNED(1)) u_sgn (
    .Clk(Clk), .Rst(Rst), .Start(start[1]), .a(a), .b(b), .quot(quot[1]), .rem(rem[1]),
    .Done(done[1]), .Busy(busy[1]), .DivByZero(dbz[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: Verilog-style truncating division on the operand interpretation.
  task automatic ref_calc(input int s, input logic [7:0] x, input logic [7:0] y);
    int sx, sy, qi, ri;
    if (y == 8'd0) begin
      exp_q = 8'hFF; exp_r = x; exp_z = 1'b1; exp_lat = 2;
    end else if (s == 0) begin
      exp_q = x / y; exp_r = x % y; exp_z = 1'b0; exp_lat = 9;
    end else begin
      sx = $signed(x); sy = $signed(y);
      qi = sx / sy; ri = sx % sy;
      exp_q = qi[7:0]; exp_r = ri[7:0]; exp_z = 1'b0; exp_lat = 9;
    end
  endtask

  // Called at #1 after an edge; the following edge is the accept edge.
  task automatic issue(input int s, input logic [7:0] x, input logic [7:0] y);
    ref_calc(s, x, y);
    a = x; b = y; start[s] = 1'b1;
    @(posedge Clk); #1;
    start[s] = 1'b0;
    check("busy_after_accept", 32'(busy[s]), 32'd1);
  endtask

  task automatic wait_check(input int s, input string tag, input int already);
    int n;
    bit got;
    n = already; got = 0;
    while (n < 40 && !got) begin
      @(posedge Clk); #1;
      n++;
      if (done[s]) got = 1;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_quot"}, 32'(quot[s]), 32'(exp_q));
    check({tag, "_rem"}, 32'(rem[s]), 32'(exp_r));
    check({tag, "_dbz"}, 32'(dbz[s]), 32'(exp_z));
    check({tag, "_busy"}, 32'(busy[s]), 32'd0);
  endtask

  task automatic check_pulse(input int s, input string tag);
    @(posedge Clk); #1;
    check({tag, "_done_low"}, 32'(done[s]), 32'd0);
    check({tag, "_hold_q"}, 32'(quot[s]), 32'(exp_q));
  endtask

  initial begin
    logic [7:0] rx, ry;
    bit         seen;
    start[0] = 1'b0; start[1] = 1'b0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("rst_quot", 32'(quot[s]), 32'd0);
      check("rst_rem", 32'(rem[s]), 32'd0);
      check("rst_done", 32'(done[s]), 32'd0);
      check("rst_busy", 32'(busy[s]), 32'd0);
      check("rst_dbz", 32'(dbz[s]), 32'd0);
    end
    seen = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (done[0] || done[1] || busy[0] || quot[0] != 0 || rem[1] != 0) seen = 1;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    issue(0, 8'd200, 8'd7);    wait_check(0, "u200_7", 0);  check_pulse(0, "u200_7");
    issue(0, 8'd255, 8'd1);    wait_check(0, "u255_1", 0);
    issue(0, 8'd5, 8'd9);      wait_check(0, "u5_9", 0);
    issue(0, 8'd255, 8'd255);  wait_check(0, "u255_255", 0);
    issue(0, 8'd77, 8'd0);     wait_check(0, "u77_0", 0);   check_pulse(0, "u77_0");

    // A Start during Busy must neither restart nor re-sample operands.
    issue(0, 8'd10, 8'd3);
    repeat (2) @(posedge Clk);
    #1 a = 8'd1; b = 8'd1; start[0] = 1'b1;
    @(posedge Clk); #1 start[0] = 1'b0;
    wait_check(0, "u10_3_ign", 3);
    check_pulse(0, "u10_3_ign");

    issue(1, 8'hF9, 8'd2);     wait_check(1, "s-7_2", 0);
    issue(1, 8'd7, 8'hFE);     wait_check(1, "s7_-2", 0);
    issue(1, 8'h80, 8'hFF);    wait_check(1, "s-128_-1", 0);
    issue(1, 8'h85, 8'd0);     wait_check(1, "s_div0", 0);

    // Back-to-back: Start asserted in the Done cycle is accepted immediately.
    issue(0, 8'd50, 8'd6);     wait_check(0, "b2b_first", 0);
    issue(0, 8'd100, 8'd10);   wait_check(0, "b2b_second", 0);

    // Reset on the 4th RUN cycle aborts with no Done and cleared outputs.
    issue(0, 8'd200, 8'd7);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    check("abort_quot", 32'(quot[0]), 32'd0);
    check("abort_rem", 32'(rem[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_dbz", 32'(dbz[0]), 32'd0);
    seen = 0;
    repeat (15) begin
      @(posedge Clk); #1;
      if (done[0] || busy[0]) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    issue(0, 8'd123, 8'd11);   wait_check(0, "after_abort", 0);

    for (int i = 0; i < 60; i++) begin
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(i % 2, rx, ry);
      wait_check(i % 2, "rand", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
